// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input
// and exposes the result through a small Wishbone slave with a level IRQ.
module pwm_capture #(
    parameter int CPT_SZ      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        pwm_i,
    input  logic [1:0]  WBs_ADR_i,
    input  logic        WBs_CYC_i,
    input  logic        WBs_STB_i,
    input  logic        WBs_WE_i,
    input  logic [31:0] WBs_DAT_i,
    output logic [31:0] WBs_DAT_o,
    output logic        WBs_ACK_o,
    output logic        irq_o
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_RISE = 2'd1;
    localparam logic [1:0] MEAS_HIGH = 2'd2;
    localparam logic [1:0] MEAS_LOW  = 2'd3;

    localparam logic [1:0] ADR_CTRL   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_DUTY   = 2'd2;
    localparam logic [1:0] ADR_PERIOD = 2'd3;

    localparam logic [CPT_SZ-1:0] CNT_MAX = '1;
    localparam logic [CPT_SZ-1:0] CNT_ONE = CPT_SZ'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;
    logic                   rise;
    logic                   fall;

    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [CPT_SZ-1:0]      cnt_q;
    logic [CPT_SZ-1:0]      cnt_d;
    logic [CPT_SZ-1:0]      high_q;
    logic [CPT_SZ-1:0]      high_d;
    logic [CPT_SZ-1:0]      duty_q;
    logic [CPT_SZ-1:0]      period_q;
    logic                   capture;
    logic                   set_ovf;

    logic                   en_q;
    logic                   irq_en_q;
    logic                   valid_q;
    logic                   ovf_q;

    logic                   ack_q;
    logic                   wr_ctrl;
    logic                   wr_status;
    logic [31:0]            rd_data;
    logic                   unused_wdat;

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

    assign ack_q     = WBs_CYC_i & WBs_STB_i & ~WBs_ACK_o;
    assign wr_ctrl   = ack_q & WBs_WE_i & (WBs_ADR_i == ADR_CTRL);
    assign wr_status = ack_q & WBs_WE_i & (WBs_ADR_i == ADR_STATUS);

    assign irq_o       = irq_en_q & (valid_q | ovf_q);
    assign unused_wdat = ^WBs_DAT_i[31:2];

    // Synchronize the async input and keep one cycle of history for edge detect
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
            prev_q <= level;
        end
    end

    // Measurement FSM next-state: counter runs continuously from the opening rise
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        high_d  = high_q;
        capture = 1'b0;
        set_ovf = 1'b0;
        if (!en_q) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = MEAS_HIGH;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        high_d  = cnt_q;
                        cnt_d   = cnt_q + CNT_ONE;
                        state_d = MEAS_LOW;
                    end else if (cnt_q == CNT_MAX) begin
                        set_ovf = 1'b1;
                        cnt_d   = '0;
                        state_d = WAIT_RISE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        capture = 1'b1;
                        cnt_d   = CNT_ONE;
                        state_d = MEAS_HIGH;
                    end else if (cnt_q == CNT_MAX) begin
                        set_ovf = 1'b1;
                        cnt_d   = '0;
                        state_d = WAIT_RISE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Measurement FSM registers; DUTY and PERIOD load together on a completed period
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            high_q   <= '0;
            duty_q   <= '0;
            period_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            high_q  <= high_d;
            if (capture) begin
                duty_q   <= high_q;
                period_q <= cnt_q;
            end
        end
    end

    // Control and sticky status flags; a hardware set beats a same-cycle clear
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en_q     <= WBs_DAT_i[0];
                irq_en_q <= WBs_DAT_i[1];
            end
            valid_q <= capture | (valid_q & ~(wr_status & WBs_DAT_i[0]));
            ovf_q   <= set_ovf | (ovf_q & ~(wr_status & WBs_DAT_i[1]));
        end
    end

    // Read mux, zero-extending the narrow fields
    always_comb begin
        rd_data = '0;
        case (WBs_ADR_i)
            ADR_CTRL:   rd_data[1:0] = {irq_en_q, en_q};
            ADR_STATUS: rd_data[2:0] = {level, ovf_q, valid_q};
            ADR_DUTY:   rd_data[CPT_SZ-1:0] = duty_q;
            ADR_PERIOD: rd_data[CPT_SZ-1:0] = period_q;
            default:    rd_data = '0;
        endcase
    end

    // Bus response: one wait state, single-cycle ACK, read data registered every cycle
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            WBs_ACK_o <= 1'b0;
            WBs_DAT_o <= '0;
        end else begin
            WBs_ACK_o <= ack_q;
            WBs_DAT_o <= rd_data;
        end
    end

endmodule
